// File: rtl/sd_spi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sd_spi_pkg
// Brief  : Shared FSM states and constants for the SD-card SPI initiator.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package sd_spi_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_t;

   localparam int         SPI_HALF_PHASES = 16;
   localparam logic [7:0] DOUT_RST        = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/sd_spi_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sd_spi_if
// Brief  : Byte-wide host request bus between the port decoder and the SPI initiator.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface sd_spi_if #(
   parameter int DIV_W = 4
);
   logic [DIV_W-1:0] div;
   logic             start;
   logic [7:0]       din;
   logic             cs_wr;
   logic             cs_val;
   logic [7:0]       dout;
   logic             busy;
   logic             done;

   modport master (
      output div, start, din, cs_wr, cs_val,
      input  dout, busy, done
   );

   modport slave (
      input  div, start, din, cs_wr, cs_val,
      output dout, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : spi_clk_div
// Brief  : Half-period counter; emits one tick every (divl+1) cycles while running.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module spi_clk_div #(
   parameter int DIV_W = 4
) (
   input  wire logic             fclk,
   input  wire logic             rst_n,
   input  wire logic             load,
   input  wire logic             run,
   input  wire logic [DIV_W-1:0] div,
   output logic                  tick
);

   logic [DIV_W-1:0] hc_q, hc_d;
   logic [DIV_W-1:0] divl_q, divl_d;

   always_comb begin
      hc_d   = hc_q;
      divl_d = divl_q;
      tick   = 1'b0;
      // The divider is latched only at load, so mid-transfer div changes are invisible.
      if (load) begin
         divl_d = div;
         hc_d   = div;
      end else if (run) begin
         if (hc_q == '0) begin
            tick = 1'b1;
            hc_d = divl_q;
         end else begin
            hc_d = hc_q - 1'b1;
         end
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         hc_q   <= '0;
         divl_q <= '0;
      end else begin
         hc_q   <= hc_d;
         divl_q <= divl_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sd_spi_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sd_spi_master
// Brief  : SPI mode-0 byte initiator for the SD slot with registered chip select.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module sd_spi_master
   import sd_spi_pkg::*;
#(
   parameter int DIV_W = 4
) (
   input  wire logic fclk,
   input  wire logic rst_n,
   sd_spi_if.slave   bus,
   output logic      sdclk,
   output logic      sddo,
   input  wire logic sddi,
   output logic      sdcs_n
);

   localparam logic [3:0] LAST_PH = 4'(SPI_HALF_PHASES - 1);

   spi_state_t state_q, state_d;
   logic [7:0] tx_sr_q, tx_sr_d;
   logic [7:0] rx_sr_q, rx_sr_d;
   logic [7:0] dout_q, dout_d;
   logic [3:0] ph_q, ph_d;
   logic       sdclk_q, sdclk_d;
   logic       sddo_q, sddo_d;
   logic       sdcs_n_q, sdcs_n_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       accept;
   logic       tick;

   // The done cycle is excluded so a new request never overlaps the done pulse.
   assign accept = (state_q == IDLE) && bus.start && !done_q;

   spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
      .fclk  (fclk),
      .rst_n (rst_n),
      .load  (accept),
      .run   (state_q == SHIFT),
      .div   (bus.div),
      .tick  (tick)
   );

   always_comb begin
      state_d  = state_q;
      tx_sr_d  = tx_sr_q;
      rx_sr_d  = rx_sr_q;
      dout_d   = dout_q;
      ph_d     = ph_q;
      sdclk_d  = sdclk_q;
      sddo_d   = sddo_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      sdcs_n_d = sdcs_n_q;

      if (bus.cs_wr && !busy_q) begin
         sdcs_n_d = bus.cs_val;
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
               busy_d  = 1'b1;
               sddo_d  = bus.din[7];
               tx_sr_d = bus.din;
               ph_d    = '0;
               sdclk_d = 1'b0;
            end
         end
         SHIFT: begin
            if (tick) begin
               sdclk_d = ~sdclk_q;
               ph_d    = ph_q + 1'b1;
               if (!sdclk_q) begin
                  rx_sr_d = {rx_sr_q[6:0], sddi};
               end else if (ph_q == LAST_PH) begin
                  sddo_d  = 1'b1;
                  dout_d  = rx_sr_q;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  sddo_d  = tx_sr_q[6];
                  tx_sr_d = {tx_sr_q[6:0], 1'b1};
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         tx_sr_q  <= '0;
         rx_sr_q  <= '0;
         dout_q   <= DOUT_RST;
         ph_q     <= '0;
         sdclk_q  <= 1'b0;
         sddo_q   <= 1'b1;
         sdcs_n_q <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tx_sr_q  <= tx_sr_d;
         rx_sr_q  <= rx_sr_d;
         dout_q   <= dout_d;
         ph_q     <= ph_d;
         sdclk_q  <= sdclk_d;
         sddo_q   <= sddo_d;
         sdcs_n_q <= sdcs_n_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign sdclk    = sdclk_q;
   assign sddo     = sddo_q;
   assign sdcs_n   = sdcs_n_q;
   assign bus.dout = dout_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_sd_spi_master
// Brief  : Vector-table and randomized bench for sd_spi_master with a card responder model.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_sd_spi_master;

   typedef struct {
      logic [7:0] din;
      logic [3:0] div;
      int         mode;          // 0 loopback, 1 sddi tied low, 2 responder byte
      logic [7:0] resp;
      int         ovr_cyc;       // busy cycle for a second start (0 = none)
      int         chg_cyc;       // busy cycle for a div change to 0 (0 = none)
      int         cs_cyc;        // busy cycle for a cs_wr deselect (0 = none)
      bit         start_in_done;
      logic [7:0] exp_dout;
      int         exp_busy;
   } vec_t;

   localparam int NVEC = 16;

   logic fclk  = 1'b0;
   logic rst_n = 1'b0;
   logic sdclk, sddo, sdcs_n, sddi;

   sd_spi_if #(.DIV_W(4)) bus ();

   sd_spi_master #(.DIV_W(4)) dut (
      .fclk   (fclk),
      .rst_n  (rst_n),
      .bus    (bus),
      .sdclk  (sdclk),
      .sddo   (sddo),
      .sddi   (sddi),
      .sdcs_n (sdcs_n)
   );

   always #5 fclk = ~fclk;

   int         cyc = 0;
   int         mode = 0;
   logic [7:0] resp_sh = 8'hFF;
   int         rise_cnt = 0;
   logic [7:0] mosi_cap = 8'h00;
   int         rise_t[8];
   int         checks = 0;
   int         errors = 0;
   vec_t       vecs[NVEC];

   always @(posedge fclk) cyc++;

   // Card side: loopback, stuck-low, or a byte presented MSB first per rising edge.
   assign sddi = (mode == 0) ? sddo : (mode == 1) ? 1'b0 : resp_sh[7];

   always @(posedge sdclk) begin
      if (rise_cnt < 8) begin
         mosi_cap[3'(7 - rise_cnt)] = sddo;
         rise_t[rise_cnt] = cyc;
      end
      rise_cnt++;
      resp_sh = {resp_sh[6:0], 1'b1};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected results straight from the transfer rules.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      r.exp_dout = (v.mode == 0) ? v.din : (v.mode == 1) ? 8'h00 : v.resp;
      r.exp_busy = 16 * (int'(v.div) + 1);
      return r;
   endfunction

   function automatic vec_t mk(input logic [7:0] din, input logic [3:0] div, input int md,
                               input logic [7:0] resp, input int ovr, input int chg,
                               input int cs, input bit sid);
      vec_t v;
      v.din = din; v.div = div; v.mode = md; v.resp = resp;
      v.ovr_cyc = ovr; v.chg_cyc = chg; v.cs_cyc = cs; v.start_in_done = sid;
      v.exp_dout = 8'h00; v.exp_busy = 0;
      return v;
   endfunction

   task automatic run_xfer(input vec_t v);
      int n = 0;
      int dn = 0;
      int per_bad = 0;
      logic [7:0] prev_dout;
      prev_dout = bus.dout;
      mode      = v.mode;
      resp_sh   = v.resp;
      rise_cnt  = 0;
      mosi_cap  = 8'h00;
      @(negedge fclk);
      bus.start = 1'b1; bus.din = v.din; bus.div = v.div;
      @(negedge fclk);
      bus.start = 1'b0; bus.din = 8'($urandom);
      chk("dout_hold", bus.dout, prev_dout);
      while (bus.busy && n < 600) begin
         n++;
         bus.start = (n == v.ovr_cyc);
         if (n == v.ovr_cyc) bus.din = 8'h00;
         if (n == v.chg_cyc) bus.div = 4'd0;
         bus.cs_wr  = (n == v.cs_cyc);
         bus.cs_val = 1'b1;
         @(negedge fclk);
         if (bus.done && bus.busy) dn++;
      end
      bus.start = 1'b0;
      bus.cs_wr = 1'b0;
      chk("busy_len", n, v.exp_busy);
      chk("done_pulse", bus.done, 1'b1);
      chk("dout", bus.dout, v.exp_dout);
      chk("sddo_idle", sddo, 1'b1);
      chk("rise_count", rise_cnt, 8);
      chk("mosi_bits", mosi_cap, v.din);
      chk("done_early", dn, 0);
      for (int k = 0; k < 7; k++)
         if (rise_t[k+1] - rise_t[k] != 2 * (int'(v.div) + 1)) per_bad++;
      chk("sdclk_period", per_bad, 0);
      if (v.start_in_done) bus.start = 1'b1;
      @(negedge fclk);
      bus.start = 1'b0;
      chk("done_clear", bus.done, 1'b0);
      chk("idle_after", bus.busy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      bus.start = 1'b0; bus.din = 8'h00; bus.div = 4'd0;
      bus.cs_wr = 1'b0; bus.cs_val = 1'b1;
      repeat (2) @(negedge fclk);
      chk("rst_sdclk", sdclk, 1'b0);
      chk("rst_sddo", sddo, 1'b1);
      chk("rst_sdcs_n", sdcs_n, 1'b1);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_dout", bus.dout, 8'hFF);
      rst_n = 1'b1;

      vecs[0] = mk(8'hA5, 4'd0,  0, 8'h00, 0, 0, 0, 1'b0);
      vecs[0].exp_dout = 8'hA5; vecs[0].exp_busy = 16;
      vecs[1] = mk(8'hFF, 4'd3,  1, 8'h00, 0, 0, 0, 1'b0);
      vecs[1].exp_dout = 8'h00; vecs[1].exp_busy = 64;
      vecs[2] = mk(8'h3C, 4'd1,  0, 8'h00, 5, 0, 0, 1'b0);
      vecs[2].exp_dout = 8'h3C; vecs[2].exp_busy = 32;
      vecs[3] = mk(8'h96, 4'd2,  0, 8'h00, 0, 3, 0, 1'b0);
      vecs[3].exp_dout = 8'h96; vecs[3].exp_busy = 48;
      vecs[4] = mk(8'hC3, 4'd0,  2, 8'h5A, 0, 0, 0, 1'b1);
      vecs[4].exp_dout = 8'h5A; vecs[4].exp_busy = 16;
      vecs[5] = mk(8'h0F, 4'd15, 2, 8'hE7, 0, 0, 0, 1'b0);
      vecs[5].exp_dout = 8'hE7; vecs[5].exp_busy = 256;
      for (int i = 6; i < NVEC; i++)
         vecs[i] = model(mk(8'($urandom), 4'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                            8'($urandom), 0, 0, 0, 1'($urandom)));

      for (int i = 0; i < NVEC; i++) run_xfer(vecs[i]);

      // Chip select: allowed while idle, locked during a byte.
      @(negedge fclk); bus.cs_wr = 1'b1; bus.cs_val = 1'b0;
      @(negedge fclk); bus.cs_wr = 1'b0;
      chk("cs_select", sdcs_n, 1'b0);
      run_xfer(model(mk(8'h55, 4'd1, 0, 8'h00, 0, 0, 4, 1'b0)));
      chk("cs_locked", sdcs_n, 1'b0);
      bus.cs_wr = 1'b1; bus.cs_val = 1'b1;
      @(negedge fclk); bus.cs_wr = 1'b0;
      chk("cs_deselect", sdcs_n, 1'b1);

      // Asynchronous reset in the middle of a byte.
      bus.cs_wr = 1'b1; bus.cs_val = 1'b0;
      @(negedge fclk); bus.cs_wr = 1'b0;
      mode = 0;
      bus.start = 1'b1; bus.din = 8'h5A; bus.div = 4'd1;
      @(negedge fclk); bus.start = 1'b0;
      repeat (6) @(negedge fclk);
      chk("pre_rst_busy", bus.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("arst_sdclk", sdclk, 1'b0);
      chk("arst_sddo", sddo, 1'b1);
      chk("arst_sdcs_n", sdcs_n, 1'b1);
      chk("arst_busy", bus.busy, 1'b0);
      chk("arst_dout", bus.dout, 8'hFF);
      @(negedge fclk); rst_n = 1'b1;
      run_xfer(model(mk(8'h81, 4'd1, 0, 8'h00, 0, 0, 0, 1'b0)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sd_spi_master.md
Name: sd_spi_master

Overview:
- FPGA-side SPI initiator for the SD-card slot; the card-side responder is the emulator already used in simulation.
- Accepts byte-wide, strobe-driven requests from the Z80 port decoder.
- Runs full-duplex SPI mode 0 transfers (MSB first) on sdclk/sddo/sddi, with a run-time clock divider.
- Holds the sdcs_n chip-select register.
- Reports completion through a busy level and a done pulse.

Parameters:
- DIV_W, 4: width of the divider input. Half-period of sdclk = (div+1) fclk cycles.

Ports:
- fclk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- div  in  DIV_W  sdclk half-period minus one; sampled only when a transfer is accepted
- start  in  1  one-cycle request to transfer din
- din  in  8  byte to transmit
- cs_wr  in  1  one-cycle strobe to write the chip-select register
- cs_val  in  1  value written to sdcs_n on cs_wr
- dout  out  8  last received byte
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- sdclk  out  1  SPI clock, idle low
- sddo  out  1  MOSI, idle high
- sddi  in  1  MISO
- sdcs_n  out  1  card select, registered

Behaviour:
- Reset (async, rst_n=0): sdclk=0, sddo=1, sdcs_n=1, busy=0, done=0, dout=8'hFF. State IDLE, counters 0. A reset mid-transfer aborts immediately; no partial dout update.
- All outputs are registered, so there is no combinational path from any input to any SPI pin.
- States: IDLE, SHIFT. "Done" is the single cycle in which the FSM leaves SHIFT.
- IDLE + start=1 (edge N), accepted:
  - busy=1, sddo=din[7], tx_sr<=din, divl<=div, hc<=div, ph<=0, sdclk stays 0; go to SHIFT.
  - busy is high from cycle N+1.
- SHIFT, each cycle:
  - hc!=0: hc decrements.
  - hc==0: hc<=divl, sdclk toggles, ph increments (4-bit).
  - Toggle 0->1 (rising edge): sample sddi into rx_sr LSB-side shift.
  - Toggle 1->0 (falling edge) with ph<15: sddo<=next tx bit.
  - Toggle 1->0 with ph==15 (16th toggle): sddo<=1, dout<=rx_sr (all 8 bits, final sample included), busy<=0, done<=1 for one cycle; go to IDLE.
- Transfer length: busy is high exactly 16*(div+1) fclk cycles. Exactly 8 rising edges. Each sddo bit is stable (div+1) cycles before and after its rising edge.
- start while busy: ignored (no queueing, din discarded).
- start in the same cycle busy falls: ignored. A new start is accepted only when busy=0 at the sampling edge.
- cs_wr:
  - busy=0: sdcs_n<=cs_val at the next edge.
  - busy=1: ignored. The select never changes mid-byte.
- cs_wr together with an accepted start: both take effect at the same edge.
- div changes during SHIFT have no effect; divl is latched at start.
- div=0: sdclk = fclk/2, the fastest mode. div=max: half-period = 2^DIV_W cycles.
- done and start never overlap at the output. done reads 0 in the cycle after it pulses.
- dout holds its value until the next done, including across new starts.

Decomposition:
- Shared package sd_spi_pkg holds:
  - state enum spi_state_t {IDLE, SHIFT}
  - constant SPI_HALF_PHASES = 16
  - reset constant DOUT_RST = 8'hFF
- Clock-enable generator sub-module spi_clk_div: owns the hc reload/decrement and emits a one-cycle tick when hc==0. The FSM and shift registers stay in the top module.

Test Plan:
- Loopback sddo->sddi, div=0, start with din=8'hA5:
  - busy high 16 cycles; 8 rising sdclk edges at 2-cycle period.
  - done pulses once; dout=8'hA5.
  - sddo returns to 1.
- sddi tied 0, div=3, din=8'hFF:
  - sdclk period 8 cycles; busy 64 cycles.
  - sddo shows 1 for all 8 bits; dout=8'h00.
- Chip select, three steps:
  - cs_wr with cs_val=0 while idle -> sdcs_n=0 next cycle.
  - Start a transfer; cs_wr with cs_val=1 mid-transfer -> sdcs_n stays 0.
  - After done, cs_wr with cs_val=1 -> sdcs_n=1.
- Overrun:
  - start with din=8'h3C, then a second start with din=8'h00 at busy cycle 5 -> only 8'h3C is shifted; a single done.
  - start asserted in the cycle done is high -> ignored, busy stays 0.
- Reset mid-transfer:
  - Assert rst_n=0 at busy cycle 7 with div=1 -> same cycle: sdclk=0, sddo=1, sdcs_n=1, busy=0, dout=8'hFF.
  - After release, a fresh 8'h81 loopback returns dout=8'h81.
- Divider latch:
  - div=2 at start; change div to 0 at busy cycle 3 -> busy still lasts 48 cycles.
